jk_bank_arbiter: RTL and testbench
==================================

Name: jk_bank_arbiter

Overview:
- Shares one bank of W JK flip-flops among N requesters; each request carries a JK command (hold/reset/set/toggle) for one bit.
- Round-robin arbiter grants at most one request per clock, applies its command to the bank at that edge, then reports completion.
- Acts as the sequencing/sharing layer in front of the JK flip-flop cell. The bank is built inside this block with the same JK truth table as the standalone cell.

Parameters:
- N, 4, number of requesters (2..16).
- W, 8, number of JK bits in the bank.
- IDX_W, 3, width of a bit index; must satisfy 2^IDX_W >= W.
- ID_W, 2, width of requester id; must satisfy 2^ID_W >= N.
- CNT_W, 16, width of the completed-operation counter.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  N  per-requester request valid.
- req_op  in  2*N  requester i uses bits [2i+1:2i] = {j,k}: 00 hold, 01 reset, 10 set, 11 toggle.
- req_idx  in  IDX_W*N  requester i uses bits [IDX_W*i +: IDX_W] as the target bit index.
- req_ready  out  N  one-hot grant, combinational; all zero when no request is valid or when rst=1.
- q  out  W  JK bank state, registered.
- done_valid  out  1  one-cycle pulse, the cycle after a handshake.
- done_id  out  ID_W  id of the completed requester.
- done_idx  out  IDX_W  index of the completed command.
- done_q  out  1  value of q[done_idx] after the command; 0 when err=1.
- err  out  1  registered with done_valid; 1 when the completed request had idx >= W.
- op_count  out  CNT_W  count of completed handshakes, including hold and err cases; wraps at 2^CNT_W.

Behaviour:
- Reset: when rst=1 at a rising edge, all state is cleared: q=0, rr_ptr=0, done_valid=0, done_id=0, done_idx=0, done_q=0, err=0, op_count=0.
- Reset priority: rst overrides any pending grant. req_ready is 0 while rst=1, so no handshake completes in a reset cycle.
- Arbitration: scan requesters rr_ptr, rr_ptr+1, …, N-1, 0, …, rr_ptr-1. The first with req_valid=1 gets req_ready=1; all others get 0.
- Handshake: a handshake completes at an edge where req_valid[i] & req_ready[i] are both 1.
  - After the handshake, rr_ptr becomes (i+1) mod N.
  - With no handshake, rr_ptr is unchanged.
- Command application, at the handshake edge (zero-cycle latency to q), for a valid index:
  - 00: q[idx] holds its value.
  - 01: q[idx] becomes 0.
  - 10: q[idx] becomes 1.
  - 11: q[idx] becomes ~q[idx].
  - All other bits hold.
- Out-of-range index (idx >= W): q is unchanged. At the next edge, done_valid=1 and err=1.
- Completion outputs: in the cycle after the handshake edge:
  - done_valid=1, with done_id, done_idx and done_q reflecting that handshake.
  - op_count has already been incremented at the handshake edge.
- done_valid is 0 in any cycle not immediately after a handshake. done_id, done_idx, done_q and err keep their last values when done_valid=0.
- Requester contract: a requester holds req_valid, req_op and req_idx stable until it sees req_ready=1. The arbiter does not buffer requests.
- Same-bit contention: requests to the same idx are serialised in grant order. Each later command sees the result of the earlier one.
- Back-to-back operation: a single requester alone with req_valid held high is granted every cycle. Each cycle applies a new command, giving one op per clock sustained.
- op_count wraps from 2^CNT_W-1 to 0 with no flag.

Test Plan:
- Reset, then requester 1 alone issues set idx 3, then toggle idx 3 in consecutive cycles (N=4, W=8):
  - q goes 0x00 → 0x08 → 0x00.
  - done_valid pulses twice with done_id=1 and done_q 1 then 0.
  - op_count=2.
- All four requesters valid at once with toggle on idx 0,1,2,3, from rr_ptr=0:
  - Grant order is 0,1,2,3, one per cycle.
  - q ends at 0x0F.
  - rr_ptr returns to 0.
- Fairness check: requesters 0 and 2 hold valid continuously for 6 cycles.
  - Grants alternate 0,2,0,2,0,2.
  - Neither requester is granted twice in a row.
- Requester 3 sends set on idx 5 and requester 0 sends reset on idx 5 in the same cycle, with rr_ptr=3:
  - Requester 3 wins first, so q[5]=1.
  - Requester 0 follows, so q[5]=0.
  - done_q sequence is 1, 0.
- Out-of-range index: with W=6 and IDX_W=3, a toggle on idx 7 leaves q unchanged, gives done_valid=1 with err=1 and done_q=0, and increments op_count.
- Reset mid-stream: assert rst for one cycle while two requesters are valid.
  - req_ready is 0 during that cycle.
  - After it, q=0, op_count=0 and done_valid=0.
  - The grant restarts from requester 0.

Source files
------------

// File: rtl/jk_bank_arbiter.sv
// Round-robin arbiter sharing one bank of W JK flip-flops among N requesters.
// One command per clock is applied at the grant edge; completion is reported a cycle later.
module jk_bank_arbiter #(
   parameter int N     = 4,
   parameter int W     = 8,
   parameter int IDX_W = 3,
   parameter int ID_W  = 2,
   parameter int CNT_W = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [N-1:0]       req_valid,
   input  logic [2*N-1:0]     req_op,
   input  logic [IDX_W*N-1:0] req_idx,
   output logic [N-1:0]       req_ready,
   output logic [W-1:0]       q,
   output logic               done_valid,
   output logic [ID_W-1:0]    done_id,
   output logic [IDX_W-1:0]   done_idx,
   output logic               done_q,
   output logic               err,
   output logic [CNT_W-1:0]   op_count
);

   logic [ID_W-1:0]  r_rr_ptr;
   logic [W-1:0]     r_q;
   logic [CNT_W-1:0] r_op_count;
   logic             r_done_vld_p1;
   logic [ID_W-1:0]  r_done_id_p1;
   logic [IDX_W-1:0] r_done_idx_p1;
   logic             r_done_q_p1;
   logic             r_err_p1;

   logic             w_any;
   logic [ID_W-1:0]  w_gnt_id;
   logic [N-1:0]     w_grant;
   logic [1:0]       w_op;
   logic [IDX_W-1:0] w_idx;
   logic             w_in_range;
   logic             w_hs;
   logic [W-1:0]     w_q_nxt;
   logic             w_bit_nxt;
   logic [ID_W-1:0]  w_ptr_nxt;

   // Pick the valid requester closest to r_rr_ptr in rotating order.
   always_comb begin
      int d;
      int best;
      d        = 0;
      best     = N;
      w_any    = 1'b0;
      w_gnt_id = '0;
      w_op     = 2'b00;
      w_idx    = '0;
      for (int i = 0; i < N; i++) begin
         d = (i - int'(r_rr_ptr) + N) % N;
         if (req_valid[i] && (d < best)) begin
            best     = d;
            w_any    = 1'b1;
            w_gnt_id = ID_W'(i);
            w_op     = req_op[2*i +: 2];
            w_idx    = req_idx[IDX_W*i +: IDX_W];
         end
      end
   end

   always_comb begin
      w_grant = '0;
      if (w_any && !rst) begin
         w_grant = N'(1) << w_gnt_id;
      end
   end

   assign req_ready  = w_grant;
   assign w_hs       = w_any & ~rst;
   assign w_in_range = (int'(w_idx) < W);
   assign w_ptr_nxt  = ID_W'((int'(w_gnt_id) + 1) % N);

   // JK truth table on the addressed bit; out-of-range indices leave the bank untouched.
   always_comb begin
      w_q_nxt   = r_q;
      w_bit_nxt = 1'b0;
      for (int b = 0; b < W; b++) begin
         if (int'(w_idx) == b) begin
            case (w_op)
               2'b00:   w_bit_nxt = r_q[b];
               2'b01:   w_bit_nxt = 1'b0;
               2'b10:   w_bit_nxt = 1'b1;
               default: w_bit_nxt = ~r_q[b];
            endcase
            w_q_nxt[b] = w_bit_nxt;
         end
      end
   end

   // Grant edge: bank, pointer and counter update; completion stage registered alongside.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rr_ptr      <= '0;
         r_q           <= '0;
         r_op_count    <= '0;
         r_done_vld_p1 <= 1'b0;
         r_done_id_p1  <= '0;
         r_done_idx_p1 <= '0;
         r_done_q_p1   <= 1'b0;
         r_err_p1      <= 1'b0;
      end else begin
         r_done_vld_p1 <= w_hs;
         if (w_hs) begin
            r_q           <= w_q_nxt;
            r_rr_ptr      <= w_ptr_nxt;
            r_op_count    <= r_op_count + CNT_W'(1);
            r_done_id_p1  <= w_gnt_id;
            r_done_idx_p1 <= w_idx;
            r_done_q_p1   <= w_bit_nxt;
            r_err_p1      <= ~w_in_range;
         end
      end
   end

   assign q          = r_q;
   assign op_count   = r_op_count;
   assign done_valid = r_done_vld_p1;
   assign done_id    = r_done_id_p1;
   assign done_idx   = r_done_idx_p1;
   assign done_q     = r_done_q_p1;
   assign err        = r_err_p1;

endmodule

// File: tb/tb_jk_bank_arbiter.sv
// Bench for jk_bank_arbiter: a reference model feeds a completion scoreboard for the
// main instance (N=4, W=8); a second instance (W=6) covers out-of-range indices.
module tb_jk_bank_arbiter;

   localparam int N = 4;
   localparam int W = 8;
   localparam int IDX_W = 3;
   localparam int ID_W = 2;
   localparam int CNT_W = 16;
   localparam int WB = 6;

   logic clk;
   logic rst;
   logic [N-1:0]       req_valid;
   logic [2*N-1:0]     req_op;
   logic [IDX_W*N-1:0] req_idx;
   logic [N-1:0]       req_ready;
   logic [W-1:0]       q;
   logic               done_valid;
   logic [ID_W-1:0]    done_id;
   logic [IDX_W-1:0]   done_idx;
   logic               done_q;
   logic               err;
   logic [CNT_W-1:0]   op_count;

   logic [N-1:0]       b_valid;
   logic [2*N-1:0]     b_op;
   logic [IDX_W*N-1:0] b_idx;
   logic [N-1:0]       b_ready;
   logic [WB-1:0]      b_q;
   logic               b_done_valid;
   logic [ID_W-1:0]    b_done_id;
   logic [IDX_W-1:0]   b_done_idx;
   logic               b_done_q;
   logic               b_err;
   logic [CNT_W-1:0]   b_op_count;

   typedef struct {
      int id;
      int idx;
      bit qb;
   } exp_t;

   exp_t sb_q[$];
   int   gnt_log[$];
   int   tests = 0;
   int   fails = 0;
   bit   sb_en = 0;

   logic [W-1:0]     m_q = '0;
   int               m_ptr = 0;
   logic [CNT_W-1:0] m_cnt = '0;

   jk_bank_arbiter #(.N(N), .W(W), .IDX_W(IDX_W), .ID_W(ID_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_op(req_op), .req_idx(req_idx),
      .req_ready(req_ready), .q(q), .done_valid(done_valid), .done_id(done_id),
      .done_idx(done_idx), .done_q(done_q), .err(err), .op_count(op_count)
   );

   jk_bank_arbiter #(.N(N), .W(WB), .IDX_W(IDX_W), .ID_W(ID_W), .CNT_W(CNT_W)) dut_b (
      .clk(clk), .rst(rst), .req_valid(b_valid), .req_op(b_op), .req_idx(b_idx),
      .req_ready(b_ready), .q(b_q), .done_valid(b_done_valid), .done_id(b_done_id),
      .done_idx(b_done_idx), .done_q(b_done_q), .err(b_err), .op_count(b_op_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Model: decide the grant, check req_ready, and queue the expected completion.
   always @(negedge clk) begin
      logic [N-1:0] eg;
      int gid;
      int c;
      int op;
      int ix;
      bit nb;
      exp_t e;
      if (sb_en) begin
         eg = '0;
         gid = -1;
         c = 0;
         if (!rst) begin
            for (int o = 0; o < N; o++) begin
               c = (m_ptr + o) % N;
               if (gid < 0 && req_valid[c]) begin
                  gid = c;
                  eg[c] = 1'b1;
               end
            end
         end
         tests++;
         if (req_ready !== eg) begin
            fails++;
            $display("FAIL ready: got %b expected %b", req_ready, eg);
         end
         for (int i = 0; i < N; i++) if (req_ready[i] === 1'b1) gnt_log.push_back(i);
         if (rst) begin
            m_q = '0;
            m_ptr = 0;
            m_cnt = '0;
            sb_q.delete();
         end else if (gid >= 0) begin
            op = int'(req_op[2*gid +: 2]);
            ix = int'(req_idx[IDX_W*gid +: IDX_W]);
            case (op)
               0: nb = m_q[ix];
               1: nb = 1'b0;
               2: nb = 1'b1;
               default: nb = ~m_q[ix];
            endcase
            m_q[ix] = nb;
            e.id = gid;
            e.idx = ix;
            e.qb = nb;
            sb_q.push_back(e);
            m_ptr = (gid + 1) % N;
            m_cnt = m_cnt + 1'b1;
         end
      end
   end

   // Scoreboard: pop the expected completion one edge later and compare.
   always @(posedge clk) begin
      exp_t e;
      if (sb_en) begin
         #1;
         tests++;
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            if (done_valid !== 1'b1 || done_id !== ID_W'(e.id) || done_idx !== IDX_W'(e.idx) ||
                done_q !== e.qb || err !== 1'b0) begin
               fails++;
               $display("FAIL done: got v=%b id=%0d idx=%0d q=%b err=%b expected v=1 id=%0d idx=%0d q=%b err=0",
                        done_valid, done_id, done_idx, done_q, err, e.id, e.idx, e.qb);
            end
         end else if (done_valid !== 1'b0) begin
            fails++;
            $display("FAIL done_idle: got done_valid=%b expected 0", done_valid);
         end
         tests++;
         if (q !== m_q || op_count !== m_cnt) begin
            fails++;
            $display("FAIL state: got q=%h cnt=%0d expected q=%h cnt=%0d", q, op_count, m_q, m_cnt);
         end
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic drop_granted();
      if (gnt_log.size() > 0) req_valid[gnt_log[$]] = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      req_valid = '0; req_op = '0; req_idx = '0;
      b_valid = '0; b_op = '0; b_idx = '0;
      sb_en = 1'b1;
      cyc(2);
      tests++;
      if (q !== 8'h00 || op_count !== 16'd0 || done_valid !== 1'b0 || req_ready !== 4'b0000 ||
          b_q !== 6'h00 || b_err !== 1'b0) begin
         fails++;
         $display("FAIL reset: got q=%h cnt=%0d dv=%b rdy=%b bq=%h berr=%b expected all zero",
                  q, op_count, done_valid, req_ready, b_q, b_err);
      end
      rst = 1'b0;
   endtask

   task automatic test_set_toggle();
      req_valid = 4'b0010;
      req_op[3:2] = 2'b10;
      req_idx[5:3] = 3'd3;
      cyc(1);
      tests++;
      if (q !== 8'h08 || done_valid !== 1'b1 || done_id !== 2'd1 || done_q !== 1'b1) begin
         fails++;
         $display("FAIL set_idx3: got q=%h dv=%b id=%0d dq=%b expected q=08 dv=1 id=1 dq=1",
                  q, done_valid, done_id, done_q);
      end
      req_op[3:2] = 2'b11;
      cyc(1);
      tests++;
      if (q !== 8'h00 || done_valid !== 1'b1 || done_id !== 2'd1 || done_q !== 1'b0 || op_count !== 16'd2) begin
         fails++;
         $display("FAIL toggle_idx3: got q=%h dv=%b id=%0d dq=%b cnt=%0d expected q=00 dv=1 id=1 dq=0 cnt=2",
                  q, done_valid, done_id, done_q, op_count);
      end
      req_valid = '0;
      cyc(1);
   endtask

   task automatic test_all_four();
      int exp_order[4] = '{0, 1, 2, 3};
      rst = 1'b1;
      cyc(1);
      rst = 1'b0;
      gnt_log.delete();
      for (int i = 0; i < N; i++) begin
         req_op[2*i +: 2] = 2'b11;
         req_idx[IDX_W*i +: IDX_W] = IDX_W'(i);
      end
      req_valid = 4'b1111;
      for (int k = 0; k < 4; k++) begin
         cyc(1);
         drop_granted();
      end
      for (int k = 0; k < 4; k++) begin
         tests++;
         if (gnt_log.size() <= k || gnt_log[k] !== exp_order[k]) begin
            fails++;
            $display("FAIL order4[%0d]: got %0d expected %0d", k,
                     (gnt_log.size() > k) ? gnt_log[k] : -1, exp_order[k]);
         end
      end
      tests++;
      if (q !== 8'h0F) begin
         fails++;
         $display("FAIL all_four_q: got %h expected 0f", q);
      end
      req_op = '0;
      req_valid = 4'b1001;
      #1;
      tests++;
      if (req_ready !== 4'b0001) begin
         fails++;
         $display("FAIL ptr_wrap: got ready=%b expected 0001", req_ready);
      end
      req_valid = '0;
      cyc(1);
   endtask

   task automatic test_fairness();
      int exp_seq[6] = '{0, 2, 0, 2, 0, 2};
      gnt_log.delete();
      req_op = '0;
      req_idx[2:0] = 3'd6;
      req_idx[8:6] = 3'd7;
      req_valid = 4'b0101;
      cyc(6);
      req_valid = '0;
      for (int k = 0; k < 6; k++) begin
         tests++;
         if (gnt_log.size() <= k || gnt_log[k] !== exp_seq[k]) begin
            fails++;
            $display("FAIL fair[%0d]: got %0d expected %0d", k,
                     (gnt_log.size() > k) ? gnt_log[k] : -1, exp_seq[k]);
         end
      end
      for (int k = 1; k < gnt_log.size(); k++) begin
         tests++;
         if (gnt_log[k] == gnt_log[k-1]) begin
            fails++;
            $display("FAIL fair_repeat[%0d]: got %0d twice expected alternation", k, gnt_log[k]);
         end
      end
      cyc(1);
   endtask

   task automatic test_contention();
      gnt_log.delete();
      req_op[7:6] = 2'b10;
      req_idx[11:9] = 3'd5;
      req_op[1:0] = 2'b01;
      req_idx[2:0] = 3'd5;
      req_valid = 4'b1001;
      cyc(1);
      tests++;
      if (q[5] !== 1'b1 || done_q !== 1'b1 || gnt_log.size() != 1 || gnt_log[0] != 3) begin
         fails++;
         $display("FAIL contend_first: got q5=%b dq=%b gnt=%0d expected q5=1 dq=1 gnt=3",
                  q[5], done_q, (gnt_log.size() > 0) ? gnt_log[0] : -1);
      end
      drop_granted();
      cyc(1);
      tests++;
      if (q[5] !== 1'b0 || done_q !== 1'b0 || gnt_log.size() != 2 || gnt_log[1] != 0) begin
         fails++;
         $display("FAIL contend_second: got q5=%b dq=%b gnt=%0d expected q5=0 dq=0 gnt=0",
                  q[5], done_q, (gnt_log.size() > 1) ? gnt_log[1] : -1);
      end
      drop_granted();
      cyc(1);
   endtask

   task automatic test_reset_mid();
      req_op = '0;
      req_valid = 4'b1001;
      rst = 1'b1;
      #1;
      tests++;
      if (req_ready !== 4'b0000) begin
         fails++;
         $display("FAIL rst_ready: got %b expected 0000", req_ready);
      end
      cyc(1);
      tests++;
      if (q !== 8'h00 || op_count !== 16'd0 || done_valid !== 1'b0) begin
         fails++;
         $display("FAIL rst_mid: got q=%h cnt=%0d dv=%b expected q=00 cnt=0 dv=0", q, op_count, done_valid);
      end
      rst = 1'b0;
      #1;
      tests++;
      if (req_ready !== 4'b0001) begin
         fails++;
         $display("FAIL rst_restart: got ready=%b expected 0001", req_ready);
      end
      gnt_log.delete();
      cyc(1);
      drop_granted();
      cyc(1);
      drop_granted();
      tests++;
      if (gnt_log.size() != 2 || gnt_log[0] != 0 || gnt_log[1] != 3) begin
         fails++;
         $display("FAIL rst_order: got %0d entries first=%0d expected 0 then 3", gnt_log.size(),
                  (gnt_log.size() > 0) ? gnt_log[0] : -1);
      end
      req_valid = '0;
      cyc(1);
   endtask

   task automatic test_out_of_range();
      b_valid = 4'b0001;
      b_op[1:0] = 2'b10;
      b_idx[2:0] = 3'd2;
      cyc(1);
      tests++;
      if (b_q !== 6'h04 || b_done_valid !== 1'b1 || b_done_q !== 1'b1 || b_err !== 1'b0) begin
         fails++;
         $display("FAIL oor_setup: got q=%h dv=%b dq=%b err=%b expected q=04 dv=1 dq=1 err=0",
                  b_q, b_done_valid, b_done_q, b_err);
      end
      b_op[1:0] = 2'b11;
      b_idx[2:0] = 3'd7;
      cyc(1);
      tests++;
      if (b_q !== 6'h04 || b_done_valid !== 1'b1 || b_err !== 1'b1 || b_done_q !== 1'b0 ||
          b_done_idx !== 3'd7 || b_done_id !== 2'd0 || b_op_count !== 16'd2) begin
         fails++;
         $display("FAIL oor: got q=%h dv=%b err=%b dq=%b idx=%0d id=%0d cnt=%0d expected q=04 dv=1 err=1 dq=0 idx=7 id=0 cnt=2",
                  b_q, b_done_valid, b_err, b_done_q, b_done_idx, b_done_id, b_op_count);
      end
      b_valid = '0;
      cyc(1);
      tests++;
      if (b_done_valid !== 1'b0 || b_err !== 1'b1 || b_done_idx !== 3'd7) begin
         fails++;
         $display("FAIL oor_hold: got dv=%b err=%b idx=%0d expected dv=0 err=1 idx=7",
                  b_done_valid, b_err, b_done_idx);
      end
   endtask

   initial begin
      test_reset();
      test_set_toggle();
      test_all_four();
      test_fairness();
      test_contention();
      test_reset_mid();
      test_out_of_range();
      cyc(2);
      sb_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
